// File: rtl/or_gate10_pkg.sv
// or_gate10_pkg: shared sizing helpers for the wide OR reduction and its popcount.
package or_gate10_pkg;
   localparam int DEF_WIDTH = 10;
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction
   function automatic int half_up(input int w);
      return (w + 1) / 2;
   endfunction
   function automatic int pow2_ceil(input int w);
      return 1 << $clog2(w);
   endfunction
endpackage

// File: rtl/or_gate10_or_tree.sv
// or_gate10_or_tree: balanced OR reduction, one pairing level per recursion step.
module or_gate10_or_tree
   import or_gate10_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] i,
   output logic             o
);
   if (WIDTH == 1) begin : g_leaf
      assign o = i[0];
   end else begin : g_lvl
      localparam int NXT = half_up(WIDTH);
      logic [NXT-1:0] pair;
      // an odd top bit has no partner and is carried up unchanged
      for (genvar k = 0; k < NXT; k++) begin : g_pair
         if (2 * k + 1 < WIDTH) begin : g_or
            assign pair[k] = i[2*k] | i[2*k+1];
         end else begin : g_pass
            assign pair[k] = i[2*k];
         end
      end
      or_gate10_or_tree #(.WIDTH(NXT)) u_next (
         .i(pair),
         .o(o)
      );
   end
endmodule

// File: rtl/or_gate10.sv
// or_gate10: wide OR with registered OR, rising-edge pulse and popcount companions.
module or_gate10
   import or_gate10_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   localparam int CNT_W = cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i,
   output logic             o,
   output logic             o_q,
   output logic             o_rise,
   output logic [CNT_W-1:0] ones_cnt
);
   localparam int NP = pow2_ceil(WIDTH);
   logic [CNT_W-1:0] node [2*NP-1];
   logic             or_q, or_d, rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   or_gate10_or_tree #(.WIDTH(WIDTH)) u_tree (
      .i(i),
      .o(o)
   );
   // heap-ordered adder tree: leaves padded with zeros up to a power of two
   for (genvar j = 0; j < NP; j++) begin : g_leaf
      if (j < WIDTH) begin : g_bit
         assign node[NP-1+j] = CNT_W'(i[j]);
      end else begin : g_pad
         assign node[NP-1+j] = '0;
      end
   end
   for (genvar k = 0; k < NP - 1; k++) begin : g_add
      assign node[k] = node[2*k+1] + node[2*k+2];
   end
   always_comb begin
      or_d   = o;
      rise_d = o & ~or_q;
      cnt_d  = node[0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         or_q   <= 1'b0;
         rise_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         or_q   <= or_d;
         rise_q <= rise_d;
         cnt_q  <= cnt_d;
      end
   end
   assign o_q      = or_q;
   assign o_rise   = rise_q;
   assign ones_cnt = cnt_q;
endmodule

// File: tb/tb_or_gate10.sv
// tb_or_gate10: directed checks of or_gate10 at widths 10, 7 and 1.
module tb_or_gate10;
   logic       clk, rst;
   logic [9:0] i10;
   logic [6:0] i7;
   logic       i1;
   logic       o10, oq10, r10, o7, oq7, r7, o1, oq1, r1;
   logic [3:0] c10;
   logic [2:0] c7;
   logic       c1;
   int         n_cmp = 0;
   int         n_bad = 0;

   or_gate10 dut (.clk(clk), .rst(rst), .i(i10), .o(o10), .o_q(oq10), .o_rise(r10), .ones_cnt(c10));
   or_gate10 #(.WIDTH(7)) dut7 (.clk(clk), .rst(rst), .i(i7), .o(o7), .o_q(oq7), .o_rise(r7), .ones_cnt(c7));
   or_gate10 #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .i(i1), .o(o1), .o_q(oq1), .o_rise(r1), .ones_cnt(c1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [9:0] seq_i [6];
      logic       seq_r [6];
      logic [3:0] seq_c [6];
      logic       p10, p7, p1;
      clk = 0; rst = 1; i10 = '0; i7 = '0; i1 = 0;
      #1;
      // combinational OR, independent of clock and reset
      chk("o_zero", o10, 0);
      i10 = 10'h001; #1; chk("o_lsb", o10, 1);
      i10 = 10'h200; #1; chk("o_msb", o10, 1);
      i10 = 10'h3FF; #1; chk("o_ones", o10, 1);
      @(posedge clk); #1;
      chk("rst_oq", oq10, 0);
      chk("rst_rise", r10, 0);
      chk("rst_cnt", c10, 0);
      @(negedge clk); i10 = '0; rst = 0;
      p10 = 0; p7 = 0; p1 = 0;
      for (int v = 0; v < 1024; v++) begin
         logic [9:0] vv;
         vv = v[9:0];
         @(negedge clk); i10 = vv; i7 = vv[6:0]; i1 = vv[0];
         #1;
         chk("sw_o10", o10, vv != 0);
         chk("sw_o7", o7, vv[6:0] != 0);
         chk("sw_o1", o1, vv[0]);
         @(posedge clk); #1;
         chk("sw_oq10", oq10, vv != 0);
         chk("sw_rise10", r10, (vv != 0) && !p10);
         chk("sw_cnt10", c10, $countones(vv));
         chk("sw_inv10", oq10, c10 != 0);
         chk("sw_oq7", oq7, vv[6:0] != 0);
         chk("sw_rise7", r7, (vv[6:0] != 0) && !p7);
         chk("sw_cnt7", c7, $countones(vv[6:0]));
         chk("sw_oq1", oq1, vv[0]);
         chk("sw_rise1", r1, vv[0] && !p1);
         chk("sw_cnt1", c1, vv[0]);
         p10 = vv != 0; p7 = vv[6:0] != 0; p1 = vv[0];
      end
      @(negedge clk); i10 = 10'h155;
      @(posedge clk); #1;
      chk("pre_oq", oq10, 1);
      chk("pre_cnt", c10, 5);
      #2; rst = 1; #1;
      chk("arst_oq", oq10, 0);
      chk("arst_rise", r10, 0);
      chk("arst_cnt", c10, 0);
      chk("arst_o", o10, 1);
      @(negedge clk); i10 = 10'h3FF; rst = 0;
      @(posedge clk); #1;
      chk("rel_oq", oq10, 1);
      chk("rel_rise", r10, 1);
      chk("rel_cnt", c10, 10);
      @(posedge clk); #1;
      chk("rel_rise2", r10, 0);
      seq_i = '{10'd0, 10'd0, 10'd5, 10'd5, 10'd0, 10'd8};
      seq_r = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      seq_c = '{4'd0, 4'd0, 4'd2, 4'd2, 4'd0, 4'd1};
      for (int s = 0; s < 6; s++) begin
         @(negedge clk); i10 = seq_i[s];
         @(posedge clk); #1;
         chk("seq_rise", r10, seq_r[s]);
         chk("seq_cnt", c10, seq_c[s]);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
